regs_param: RTL and testbench

//  Parametrised integer register file for the RISC-V pipeline: 2 async read ports, 1 sync write port, x0 hardwired 0.

---
 rtl/regs_param.sv | 155 +++++++++++++++
 tb/tb_regs_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regs_param.sv
//-----------------------------------------------------------------------------
// regs_param
//   Parametrised integer register file for the RISC-V pipeline.
//   Two combinational read ports (ID stage) and one synchronous write port
//   (WB stage). x0 always reads as zero.
//
//   The storage array has no reset. After rst_n is released, an init
//   sequencer clears one register per clock. 'ready' stays low until all
//   NREG registers are cleared. While 'ready' is low, both read ports return
//   zero and external writes are ignored.
//
//   Optional feature, enabled by defining the macro REGS_BYPASS_EN:
//     A write in the READY state is forwarded to a read port that addresses
//     the same non-zero register in the same cycle. Without the macro, the
//     written value becomes visible from the next cycle.
//
// Parameters
//   XLEN  data width in bits
//   AW    register index width; NREG = 1 << AW (derived, not overridable)
//
// Ports
//   clk     in   1     clock, rising edge
//   rst_n   in   1     asynchronous reset, active-low
//   rs1     in   AW    read index A
//   rs2     in   AW    read index B
//   rd      in   AW    write index
//   wb      in   XLEN  write-back data
//   RegWen  in   1     write enable
//   dataA   out  XLEN  read data A (combinational)
//   dataB   out  XLEN  read data B (combinational)
//   ready   out  1     1 = initialisation done, file usable
//-----------------------------------------------------------------------------
module regs_param #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wb,
   input  logic            RegWen,
   output logic [XLEN-1:0] dataA,
   output logic [XLEN-1:0] dataB,
   output logic            ready
);

   localparam int          NREG     = 1 << AW;
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   init_cnt;

   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [XLEN-1:0] mem_wdata;

   logic [XLEN-1:0] mem [NREG];

   //--------------------------------------------------------------------------
   // State register and init counter
   //--------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT)
            init_cnt <= init_cnt + AW'(1);
      end
   end

   //--------------------------------------------------------------------------
   // Next-state logic: INIT -> READY once the last register is being cleared
   //--------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  if (init_cnt == LAST_IDX) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_INIT;
      endcase
   end

   //--------------------------------------------------------------------------
   // Output / write-port steering
   //   INIT  : the sequencer owns the write port and ignores RegWen
   //   READY : external writes, except writes to x0
   //--------------------------------------------------------------------------
   always_comb begin
      ready     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = rd;
      mem_wdata = wb;
      case (state)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = '0;
         end
         ST_READY: begin
            ready  = 1'b1;
            mem_we = RegWen && (rd != '0);
         end
         default: ;
      endcase
   end

   //--------------------------------------------------------------------------
   // Storage
   //--------------------------------------------------------------------------
   // NOTE: the array has no reset. It maps onto plain RAM/flops without
   // reset wiring, and the init sequencer provides the clearing instead.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   //--------------------------------------------------------------------------
   // Read ports: zero while not ready or when addressing x0
   //--------------------------------------------------------------------------
   always_comb begin
      dataA = '0;
      if (ready && (rs1 != '0)) begin
         dataA = mem[rs1];
`ifdef REGS_BYPASS_EN
         if (RegWen && (rd == rs1))
            dataA = wb;
`endif
      end
   end

   always_comb begin
      dataB = '0;
      if (ready && (rs2 != '0)) begin
         dataB = mem[rs2];
`ifdef REGS_BYPASS_EN
         if (RegWen && (rd == rs2))
            dataB = wb;
`endif
      end
   end

endmodule

// File: tb/tb_regs_param.sv
//-----------------------------------------------------------------------------
// tb_regs_param
//   Directed self-checking bench for regs_param. It uses two instances that
//   share clk and rst_n:
//     u_dut    default parameters (XLEN=32, AW=5)
//     u_dut64  XLEN=64, AW=4
//   Expected values for the same-cycle hazard follow the REGS_BYPASS_EN
//   macro in use for the build.
//-----------------------------------------------------------------------------
module tb_regs_param;

   logic        clk;
   logic        rst_n;

   // 32x32 instance
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] wb;
   logic        RegWen;
   logic [31:0] dataA, dataB;
   logic        ready;

   // 64-bit, 16-entry instance
   logic [3:0]  rs1_w, rs2_w, rd_w;
   logic [63:0] wb_w;
   logic        RegWen_w;
   logic [63:0] dataA_w, dataB_w;
   logic        ready_w;

   int n_tests = 0;
   int n_fail  = 0;

   regs_param u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd),
      .wb     (wb),
      .RegWen (RegWen),
      .dataA  (dataA),
      .dataB  (dataB),
      .ready  (ready)
   );

   regs_param #(.XLEN(64), .AW(4)) u_dut64 (
      .clk    (clk),
      .rst_n  (rst_n),
      .rs1    (rs1_w),
      .rs2    (rs2_w),
      .rd     (rd_w),
      .wb     (wb_w),
      .RegWen (RegWen_w),
      .dataA  (dataA_w),
      .dataB  (dataB_w),
      .ready  (ready_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one rising edge, then move off the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_hazard;

   initial begin
      rst_n    = 1'b0;
      rs1      = '0; rs2 = '0; rd = '0; wb = '0; RegWen = 1'b0;
      rs1_w    = '0; rs2_w = '0; rd_w = '0; wb_w = '0; RegWen_w = 1'b0;

      // ---- 1/3: reset, init length, writes attempted during INIT ----
      // Keep a write to x5 requested throughout INIT. It must never land.
      rd = 5'd5; wb = 32'hDEAD_BEEF; RegWen = 1'b1; rs1 = 5'd5; rs2 = 5'd5;
      #1;
      check("rst_ready",  64'(ready),   64'd0);
      check("rst_dataA",  64'(dataA),   64'd0);
      check("rst_ready64",64'(ready_w), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         step();
         if (e == 1)  check("init_e1_ready",   64'(ready),   64'd0);
         if (e == 15) check("init64_e15_ready",64'(ready_w), 64'd0);
         if (e == 16) check("init64_e16_ready",64'(ready_w), 64'd1);
         if (e == 31) begin
            check("init_e31_ready", 64'(ready), 64'd0);
            check("init_e31_dataA", 64'(dataA), 64'd0);
         end
         if (e == 32) check("init_e32_ready", 64'(ready), 64'd1);
      end
      RegWen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i);
         #1;
         check($sformatf("clr_A[%0d]", i), 64'(dataA), 64'd0);
         check($sformatf("clr_B[%0d]", 31 - i), 64'(dataB), 64'd0);
      end

      // ---- 2: write sweep with wb=1, then with index-tagged data ----
      for (int i = 0; i < 32; i++) begin
         rd = 5'(i); wb = 32'h1; RegWen = 1'b1;
         step();
      end
      RegWen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(i);
         #1;
         check($sformatf("sw1_A[%0d]", i), 64'(dataA), (i == 0) ? 64'd0 : 64'd1);
         check($sformatf("sw1_B[%0d]", i), 64'(dataB), (i == 0) ? 64'd0 : 64'd1);
      end
      for (int i = 0; i < 32; i++) begin
         rd = 5'(i); wb = 32'h1000_0000 + 32'(i); RegWen = 1'b1;
         step();
      end
      RegWen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i);
         #1;
         check($sformatf("sw2_A[%0d]", i), 64'(dataA),
               (i == 0) ? 64'd0 : 64'(32'h1000_0000 + 32'(i)));
         check($sformatf("sw2_B[%0d]", 31 - i), 64'(dataB),
               (i == 31) ? 64'd0 : 64'(32'h1000_0000 + 32'(31 - i)));
      end

      // ---- 4: same-cycle write/read hazard on x7 ----
      rd = 5'd7; wb = 32'h0; RegWen = 1'b1;
      step();
`ifdef REGS_BYPASS_EN
      exp_hazard = 32'hA5A5_A5A5;
`else
      exp_hazard = 32'h0;
`endif
      rs1 = 5'd7; rs2 = 5'd7; rd = 5'd7; wb = 32'hA5A5_A5A5; RegWen = 1'b1;
      #1;
      check("haz_same_A", 64'(dataA), 64'(exp_hazard));
      check("haz_same_B", 64'(dataB), 64'(exp_hazard));
      step();
      RegWen = 1'b0;
      #1;
      check("haz_next_A", 64'(dataA), 64'h0000_0000_A5A5_A5A5);
      check("haz_next_B", 64'(dataB), 64'h0000_0000_A5A5_A5A5);
      // x0 is never forwarded
      rs1 = 5'd0; rd = 5'd0; wb = 32'hFFFF_FFFF; RegWen = 1'b1;
      #1;
      check("haz_x0_same", 64'(dataA), 64'd0);
      step();
      RegWen = 1'b0;
      #1;
      check("haz_x0_next", 64'(dataA), 64'd0);

      // ---- 6: 64-bit / 16-entry instance ----
      rd_w = 4'd15; wb_w = 64'hFFFF_0000_1234_5678; RegWen_w = 1'b1;
      step();
      rd_w = 4'd0; wb_w = '1;
      step();
      RegWen_w = 1'b0; rs1_w = 4'd15; rs2_w = 4'd0;
      #1;
      check("w64_x15", dataA_w, 64'hFFFF_0000_1234_5678);
      check("w64_x0",  dataB_w, 64'd0);
      rs1_w = 4'd14;
      #1;
      check("w64_x14", dataA_w, 64'd0);

      // ---- 5: reset in mid-operation ----
      rd = 5'd3; wb = 32'h1234; RegWen = 1'b1;
      step();
      RegWen = 1'b0; rs1 = 5'd3;
      #1;
      check("mid_pre_x3", 64'(dataA), 64'h1234);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 64'(ready), 64'd0);
      check("mid_rst_dataA", 64'(dataA), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         step();
         if (e == 31) check("re_e31_ready", 64'(ready), 64'd0);
         if (e == 32) check("re_e32_ready", 64'(ready), 64'd1);
      end
      #1;
      check("re_x3", 64'(dataA), 64'd0);
      rs1_w = 4'd15;
      #1;
      check("re64_x15", dataA_w, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
